// File: rtl/axis_pair_arbiter.sv
// axis_pair_arbiter
//
// Round-robin AXI-Stream arbiter that puts N requesters onto one W-bit stream
// feeding a W-to-2W upsizer. A grant is held for exactly BEATS accepted beats,
// so every upsized word is built from a single source. The data path is a
// purely combinational mux. The granted index travels with each beat on
// out_tid.
//
// Ports
//   aclk        clock, rising edge
//   aresetn     asynchronous active-low reset
//   in_tdata    N*W   requester data, slice i is [i*W +: W]
//   in_tvalid   N     per-requester valid
//   in_tready   N     per-requester ready, one-hot or zero
//   out_tdata   W     data of the granted requester
//   out_tid     IDW   index of the granted requester
//   out_tlast   1     last beat (BEATS-1) of a grant
//   out_tvalid  1     valid toward the upsizer
//   out_tready  1     ready from the upsizer

module axis_pair_arbiter #(
    parameter int unsigned W     = 40,
    parameter int unsigned N     = 4,
    parameter int unsigned BEATS = 2,
    parameter int unsigned IDW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [N*W-1:0]     in_tdata,
    input  logic [N-1:0]       in_tvalid,
    output logic [N-1:0]       in_tready,
    output logic [W-1:0]       out_tdata,
    output logic [IDW-1:0]     out_tid,
    output logic               out_tlast,
    output logic               out_tvalid,
    input  logic               out_tready
);

    localparam int unsigned    CW       = $clog2(BEATS) + 1;
    localparam logic [CW-1:0]  LastBeat = CW'(BEATS - 1);
    localparam logic [IDW-1:0] LastId   = IDW'(N - 1);

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            locked;
    logic            last_beat;
    logic            hs;
    logic [IDW-1:0]  grant_succ;
    logic [IDW:0]    pick_idle;
    logic [IDW:0]    pick_next;

    // Round-robin pick: first valid requester scanning start, start+1, ...,
    // N-1, 0, ..., start-1. Result is {found, index}. start is always < N, so
    // a single subtraction wraps the scan index back into range.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0]   req,
                                             input logic [IDW-1:0] start);
        logic [IDW:0] res;
        int unsigned  idx;
        res = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!res[IDW] && req[idx]) begin
                res = {1'b1, idx[IDW-1:0]};
            end
        end
        return res;
    endfunction

    assign locked    = (state_q == StLocked);
    assign last_beat = (cnt_q == LastBeat);
    assign hs        = locked & in_tvalid[grant_q] & out_tready;

    // N need not be a power of two, so the successor wraps explicitly.
    assign grant_succ = (grant_q == LastId) ? '0 : grant_q + IDW'(1);

    assign pick_idle = rr_pick(in_tvalid, ptr_q);
    // Scanning from the successor leaves the current owner at lowest priority
    // while its own valid still counts as a request.
    assign pick_next = rr_pick(in_tvalid, grant_succ);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (|in_tvalid) begin
                    state_d = StLocked;
                    grant_d = pick_idle[IDW-1:0];
                    cnt_d   = '0;
                end
            end
            StLocked: begin
                // Lock holds until BEATS beats are accepted, even if the owner
                // drops valid between beats.
                if (hs) begin
                    if (!last_beat) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        ptr_d = grant_succ;
                        cnt_d = '0;
                        if (pick_next[IDW]) begin
                            grant_d = pick_next[IDW-1:0];
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output mux and ready steering
    always_comb begin
        in_tready  = '0;
        out_tvalid = 1'b0;
        out_tdata  = '0;
        out_tid    = '0;
        out_tlast  = 1'b0;
        if (locked) begin
            out_tvalid         = in_tvalid[grant_q];
            out_tdata          = in_tdata[32'(grant_q) * W +: W];
            out_tid            = grant_q;
            out_tlast          = last_beat;
            in_tready[grant_q] = out_tready;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_pair_arbiter.sv
// Testbench for axis_pair_arbiter: directed scenarios on a 4-source instance
// and a randomized fairness/ordering run on a 3-source instance.
// Inputs are driven just after the falling edge; outputs are sampled 1 time
// unit later, i.e. the values the next rising edge will act on.

module tb_axis_pair_arbiter;

    localparam int W     = 40;
    localparam int BEATS = 2;

    logic clk;
    logic aresetn;

    // 4-source instance
    logic [4*W-1:0] a_data;
    logic [3:0]     a_valid;
    logic [3:0]     a_ready;
    logic [W-1:0]   a_odata;
    logic [1:0]     a_tid;
    logic           a_tlast;
    logic           a_ovalid;
    logic           a_oready;

    // 3-source instance
    logic [3*W-1:0] b_data;
    logic [2:0]     b_valid;
    logic [2:0]     b_ready;
    logic [W-1:0]   b_odata;
    logic [1:0]     b_tid;
    logic           b_tlast;
    logic           b_ovalid;
    logic           b_oready;

    int total;
    int bad;

    axis_pair_arbiter #(.W(W), .N(4), .BEATS(BEATS)) u_arb4 (
        .aclk       (clk),
        .aresetn    (aresetn),
        .in_tdata   (a_data),
        .in_tvalid  (a_valid),
        .in_tready  (a_ready),
        .out_tdata  (a_odata),
        .out_tid    (a_tid),
        .out_tlast  (a_tlast),
        .out_tvalid (a_ovalid),
        .out_tready (a_oready)
    );

    axis_pair_arbiter #(.W(W), .N(3), .BEATS(BEATS)) u_arb3 (
        .aclk       (clk),
        .aresetn    (aresetn),
        .in_tdata   (b_data),
        .in_tvalid  (b_valid),
        .in_tready  (b_ready),
        .out_tdata  (b_odata),
        .out_tid    (b_tid),
        .out_tlast  (b_tlast),
        .out_tvalid (b_ovalid),
        .out_tready (b_oready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat payload: source index in the top byte, per-source sequence below.
    function automatic logic [W-1:0] sw(input int s, input int q);
        return {s[7:0], q[31:0]};
    endfunction

    // Expected 4-source output bundle {valid, tid, last, in_tready, data}.
    function automatic logic [47:0] pk(input logic v, input int t, input logic l,
                                       input logic [3:0] r, input logic [W-1:0] d);
        return {v, t[1:0], l, r, d};
    endfunction

    function automatic logic [3:0] oh4(input int t);
        logic [3:0] r;
        r = '0;
        r[t] = 1'b1;
        return r;
    endfunction

    task automatic apply_reset();
        aresetn  = 1'b0;
        a_valid  = '0;
        a_data   = '0;
        a_oready = 1'b0;
        b_valid  = '0;
        b_data   = '0;
        b_oready = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [47:0] obs;
        aresetn  = 1'b0;
        a_valid  = 4'hf;
        a_oready = 1'b1;
        b_valid  = 3'h7;
        b_oready = 1'b1;
        @(negedge clk);
        #1;
        obs = {a_ovalid, a_tid, a_tlast, a_ready, a_odata};
        total++;
        if (obs !== 48'h0) begin
            bad++;
            $display("FAIL reset_a: got %h want %h", obs, 48'h0);
        end
        total++;
        if ({b_ovalid, b_tid, b_tlast, b_ready, b_odata} !== 47'h0) begin
            bad++;
            $display("FAIL reset_b: got %h want 0",
                     {b_ovalid, b_tid, b_tlast, b_ready, b_odata});
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] beats [6];
        logic [47:0]  obs, exp;
        int           bi;
        beats[0] = "ABCDE";
        beats[1] = "FGHIJ";
        beats[2] = "KLMNO";
        beats[3] = "PQRST";
        beats[4] = "UVWXY";
        beats[5] = "Zabcd";
        apply_reset();
        a_oready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bi = (c == 0) ? 0 : ((c < 7) ? c - 1 : 5);
            a_valid          = (c < 7) ? 4'b0010 : 4'b0000;
            a_data[W +: W]   = beats[bi];
            #1;
            obs = {a_ovalid, a_tid, a_tlast, a_ready, a_odata};
            if (c == 0)      exp = pk(1'b0, 0, 1'b0, 4'b0000, '0);
            else if (c < 7)  exp = pk(1'b1, 1, ((c - 1) % 2) == 1, 4'b0010, beats[bi]);
            else             exp = pk(1'b0, 1, 1'b0, 4'b0010, beats[5]);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL back_to_back c=%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_all_valid();
        int          order [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        int          drv [4];
        int          exq [4];
        logic [47:0] obs, exp;
        int          t;
        apply_reset();
        a_oready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            drv[s] = 0;
            exq[s] = 0;
        end
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            a_valid = 4'hf;
            for (int s = 0; s < 4; s++) a_data[s*W +: W] = sw(s, drv[s]);
            #1;
            obs = {a_ovalid, a_tid, a_tlast, a_ready, a_odata};
            if (c == 0) begin
                exp = pk(1'b0, 0, 1'b0, 4'b0000, '0);
            end else begin
                t   = order[c-1];
                exp = pk(1'b1, t, ((c - 1) % 2) == 1, oh4(t), sw(t, exq[t]));
                exq[t]++;
            end
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL all_valid c=%0d: got %h want %h", c, obs, exp);
            end
            for (int s = 0; s < 4; s++) if (a_valid[s] && a_ready[s]) drv[s]++;
        end
    endtask

    task automatic test_gap_mid_pair();
        int          drv0;
        logic [47:0] obs, exp;
        apply_reset();
        a_oready = 1'b1;
        drv0     = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a_valid[2]       = (c <= 1) || (c == 5);
            a_valid[0]       = (c >= 1);
            a_valid[1]       = 1'b0;
            a_valid[3]       = 1'b0;
            a_data[2*W +: W] = sw(2, (c < 5) ? 0 : 1);
            a_data[0 +: W]   = sw(0, drv0);
            #1;
            obs = {a_ovalid, a_tid, a_tlast, a_ready, a_odata};
            case (c)
                0:       exp = pk(1'b0, 0, 1'b0, 4'b0000, '0);
                1:       exp = pk(1'b1, 2, 1'b0, 4'b0100, sw(2, 0));
                5:       exp = pk(1'b1, 2, 1'b1, 4'b0100, sw(2, 1));
                6:       exp = pk(1'b1, 0, 1'b0, 4'b0001, sw(0, 0));
                7:       exp = pk(1'b1, 0, 1'b1, 4'b0001, sw(0, 1));
                default: exp = pk(1'b0, 2, 1'b1, 4'b0100, sw(2, 0));
            endcase
            // During the gap cnt has already advanced past beat 0.
            if (c >= 2 && c <= 4) exp = pk(1'b0, 2, 1'b1, 4'b0100, sw(2, 0));
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL gap_mid_pair c=%0d: got %h want %h", c, obs, exp);
            end
            if (a_valid[0] && a_ready[0]) drv0++;
        end
    endtask

    task automatic test_backpressure();
        int          order [3] = '{0, 1, 3};
        int          drv [4];
        int          exq [4];
        int          k;
        int          t;
        logic [47:0] obs, exp;
        apply_reset();
        for (int s = 0; s < 4; s++) begin
            drv[s] = 0;
            exq[s] = 0;
        end
        k = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            a_oready = (c % 2) == 1;
            a_valid  = 4'b1011;
            for (int s = 0; s < 4; s++) a_data[s*W +: W] = sw(s, drv[s]);
            #1;
            obs = {a_ovalid, a_tid, a_tlast, a_ready, a_odata};
            if (c == 0) begin
                exp = pk(1'b0, 0, 1'b0, 4'b0000, '0);
            end else begin
                t   = order[(k / 2) % 3];
                exp = pk(1'b1, t, (k % 2) == 1, a_oready ? oh4(t) : 4'b0000,
                         sw(t, exq[t]));
                if (a_oready) begin
                    k++;
                    exq[t]++;
                end
            end
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL backpressure c=%0d: got %h want %h", c, obs, exp);
            end
            for (int s = 0; s < 4; s++) if (a_valid[s] && a_ready[s]) drv[s]++;
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [47:0] obs, exp;
        apply_reset();
        a_oready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            a_valid          = (c == 0) ? 4'b0100 : ((c < 3) ? 4'b1100 : 4'b1000);
            a_data[2*W +: W] = sw(2, (c == 2) ? 1 : 0);
            a_data[3*W +: W] = sw(3, 0);
            #1;
            obs = {a_ovalid, a_tid, a_tlast, a_ready, a_odata};
            case (c)
                0:       exp = pk(1'b0, 0, 1'b0, 4'b0000, '0);
                1:       exp = pk(1'b1, 2, 1'b0, 4'b0100, sw(2, 0));
                2:       exp = pk(1'b1, 2, 1'b1, 4'b0100, sw(2, 1));
                default: exp = pk(1'b1, 3, 1'b0, 4'b1000, sw(3, 0));
            endcase
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_mid_grant c=%0d: got %h want %h", c, obs, exp);
            end
        end
        // Beat 0 of the grant to source 3 is accepted; now reset mid-pair.
        @(negedge clk);
        a_data[3*W +: W] = sw(3, 1);
        #1;
        aresetn = 1'b0;
        #1;
        total++;
        if ({a_ovalid, a_ready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_async_drop: got %b want 00000", {a_ovalid, a_ready});
        end
        @(negedge clk);
        a_valid          = 4'b1010;
        a_data[1*W +: W] = sw(1, 0);
        aresetn          = 1'b1;
        #1;
        obs = {a_ovalid, a_tid, a_tlast, a_ready, a_odata};
        exp = pk(1'b0, 0, 1'b0, 4'b0000, '0);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_release_idle: got %h want %h", obs, exp);
        end
        @(negedge clk);
        #1;
        obs = {a_ovalid, a_tid, a_tlast, a_ready, a_odata};
        exp = pk(1'b1, 1, 1'b0, 4'b0010, sw(1, 0));
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_first_grant: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_random_fairness();
        int         bseq [3];
        int         sb_next [3];
        int         wt [3];
        logic [2:0] take;
        int         pair_pos;
        int         pair_tid;
        int         hs_count;
        int         t;
        logic       hs;
        apply_reset();
        for (int s = 0; s < 3; s++) begin
            bseq[s]    = 0;
            sb_next[s] = 0;
            wt[s]      = 0;
        end
        take     = '0;
        pair_pos = 0;
        pair_tid = 0;
        hs_count = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            // Sources hold valid and data until accepted.
            for (int s = 0; s < 3; s++) begin
                if (take[s]) begin
                    bseq[s]++;
                    b_valid[s] = ($urandom_range(0, 3) != 0);
                end else if (!b_valid[s]) begin
                    b_valid[s] = ($urandom_range(0, 1) == 1);
                end
                b_data[s*W +: W] = sw(s, bseq[s]);
            end
            b_oready = ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if (!$onehot0(b_ready)) begin
                bad++;
                $display("FAIL rand_ready_onehot c=%0d: got %b want one-hot or zero",
                         c, b_ready);
            end
            hs   = b_ovalid && b_oready;
            take = b_valid & b_ready;
            total++;
            if ((|take) !== hs) begin
                bad++;
                $display("FAIL rand_take_vs_hs c=%0d: got take=%b hs=%b want matching",
                         c, take, hs);
            end
            t = int'(b_tid);
            if (hs) begin
                hs_count++;
                total++;
                if (t > 2) begin
                    bad++;
                    $display("FAIL rand_tid_range c=%0d: got %0d want <3", c, t);
                end else begin
                    if (b_odata !== sw(t, sb_next[t])) begin
                        bad++;
                        $display("FAIL rand_order c=%0d: got %h want %h",
                                 c, b_odata, sw(t, sb_next[t]));
                    end
                    sb_next[t]++;
                end
                if (pair_pos == 0) begin
                    pair_tid = t;
                end else begin
                    total++;
                    if (t != pair_tid) begin
                        bad++;
                        $display("FAIL rand_pair_tid c=%0d: got %0d want %0d", c, t, pair_tid);
                    end
                end
                total++;
                if (b_tlast !== (pair_pos == BEATS - 1)) begin
                    bad++;
                    $display("FAIL rand_tlast c=%0d: got %b want %b",
                             c, b_tlast, (pair_pos == BEATS - 1));
                end
                pair_pos = (pair_pos + 1) % BEATS;
            end
            for (int s = 0; s < 3; s++) begin
                if (!b_valid[s]) begin
                    wt[s] = 0;
                end else if (hs && t == s) begin
                    wt[s] = 0;
                end else if (hs) begin
                    wt[s]++;
                    total++;
                    if (wt[s] > (3 - 1) * BEATS) begin
                        bad++;
                        $display("FAIL rand_starve c=%0d src=%0d: got wait %0d want <= %0d",
                                 c, s, wt[s], (3 - 1) * BEATS);
                    end
                end
            end
        end
        total++;
        if (hs_count < 200) begin
            bad++;
            $display("FAIL rand_throughput: got %0d beats want >= 200", hs_count);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        aresetn  = 1'b0;
        a_valid  = '0;
        a_data   = '0;
        a_oready = 1'b0;
        b_valid  = '0;
        b_data   = '0;
        b_oready = 1'b0;
        test_reset();
        test_back_to_back();
        test_all_valid();
        test_gap_mid_pair();
        test_backpressure();
        test_reset_mid_grant();
        test_random_fairness();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
